// File: rtl/bsg_mux_rr_buffered_pkg.sv
// Shared helpers for the buffered round-robin mux.
// Contents:
//   sel_width - width of a channel index for a given channel count
//               (at least 1 bit, so that a single channel still has a legal port)
package bsg_mux_rr_buffered_pkg;

    function automatic int sel_width(input int els);
        return (els == 1) ? 1 : $clog2(els);
    endfunction

endpackage

// File: rtl/bsg_mux_rr_buffered_arb.sv
// Combinational round-robin / forced-select arbiter.
// Ports:
//   v_i         channel valids
//   last_i      index of the most recent round-robin winner; the search starts just after it
//   force_v_i   1: grant only channel force_sel_i (if it is valid)
//   force_sel_i forced channel index; values >= els_p grant nothing
//   gnt_o       one-hot grant (zero when nothing is granted)
//   gnt_idx_o   index of the granted channel (meaningful only when gnt_o != 0)
module bsg_mux_rr_arb
    import bsg_mux_rr_buffered_pkg::*;
#(
    parameter  int els_p        = 2,
    localparam int sel_width_lp = sel_width(els_p)
) (
    input  logic [els_p-1:0]        v_i,
    input  logic [sel_width_lp-1:0] last_i,
    input  logic                    force_v_i,
    input  logic [sel_width_lp-1:0] force_sel_i,
    output logic [els_p-1:0]        gnt_o,
    output logic [sel_width_lp-1:0] gnt_idx_o
);

    logic found_s;
    logic hit_s;

    // Grant selection: forced index, or first valid channel after last_i (wrapping).
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found_s   = 1'b0;
        hit_s     = 1'b0;
        if (force_v_i) begin
            // An out-of-range force_sel_i never matches any c, so nothing is granted.
            for (int c = 0; c < els_p; c++) begin
                gnt_o[c] = v_i[c] && (int'(force_sel_i) == c);
            end
            gnt_idx_o = force_sel_i;
        end else begin
            // Offset j visits last+1, last+2, ..., last+els_p (= last itself, last priority).
            for (int j = 1; j <= els_p; j++) begin
                for (int c = 0; c < els_p; c++) begin
                    hit_s     = !found_s && v_i[c] && (c == ((int'(last_i) + j) % els_p));
                    gnt_o[c]  = gnt_o[c] | hit_s;
                    gnt_idx_o = hit_s ? sel_width_lp'(c) : gnt_idx_o;
                    found_s   = found_s | hit_s;
                end
            end
        end
    end

endmodule

// File: rtl/bsg_mux_rr_buffered_chk.sv
// Simulation checker for the buffered mux handshake.
// Ports (all inputs): clk_i, reset_i, data_i, v_i, yumi_i (the mux's yumi_o).
// Checks that a producer holding valid keeps valid and data steady until consumed,
// and that at most one channel is consumed per cycle.
module bsg_mux_rr_buffered_chk #(
    parameter int width_p = 64,
    parameter int els_p   = 2
) (
    input logic                       clk_i,
    input logic                       reset_i,
    input logic [els_p*width_p-1:0]   data_i,
    input logic [els_p-1:0]           v_i,
    input logic [els_p-1:0]           yumi_i
);

    for (genvar k = 0; k < els_p; k++) begin : g_ch
        a_hold: assert property (@(posedge clk_i) disable iff (reset_i)
            (v_i[k] && !yumi_i[k]) |=> (v_i[k] && $stable(data_i[k*width_p +: width_p])))
            else $error("producer dropped valid or changed data before yumi on channel %0d", k);
    end

    a_onehot: assert property (@(posedge clk_i) disable iff (reset_i) $onehot0(yumi_i))
        else $error("yumi is not one-hot");

endmodule

// File: rtl/bsg_mux_rr_buffered.sv
// Registered N-to-1 mux with round-robin arbitration and a one-entry output register.
// Ports:
//   clk_i, reset_i  clock, synchronous active-high reset
//   data_i, v_i     els_p producer channels (channel k at data_i[k*width_p +: width_p])
//   yumi_o          channel consumed this cycle (one-hot or zero)
//   force_v_i/force_sel_i  serve only the given channel, bypassing round-robin
//   data_o, sel_o, v_o     registered output word, its source channel, valid
//   ready_and_i     consumer accepts data_o when v_o & ready_and_i
module bsg_mux_rr_buffered
    import bsg_mux_rr_buffered_pkg::*;
#(
    parameter  int width_p      = 64,
    parameter  int els_p        = 2,
    localparam int sel_width_lp = sel_width(els_p)
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [els_p*width_p-1:0]  data_i,
    input  logic [els_p-1:0]          v_i,
    output logic [els_p-1:0]          yumi_o,
    input  logic                      force_v_i,
    input  logic [sel_width_lp-1:0]   force_sel_i,
    output logic [width_p-1:0]        data_o,
    output logic [sel_width_lp-1:0]   sel_o,
    output logic                      v_o,
    input  logic                      ready_and_i
);

    // Pointer starts at the last channel so channel 0 wins first after reset.
    localparam logic [sel_width_lp-1:0] last_init_lp = sel_width_lp'(els_p - 1);

    logic                    v_q,    v_d;
    logic [width_p-1:0]      data_q, data_d;
    logic [sel_width_lp-1:0] sel_q,  sel_d;
    logic [sel_width_lp-1:0] last_q, last_d;

    logic                    en_s;
    logic [els_p-1:0]        gnt_s;
    logic [sel_width_lp-1:0] gnt_idx_s;
    logic [width_p-1:0]      gnt_data_s;

    bsg_mux_rr_arb #(.els_p(els_p)) u_arb (
        .v_i         (v_i),
        .last_i      (last_q),
        .force_v_i   (force_v_i),
        .force_sel_i (force_sel_i),
        .gnt_o       (gnt_s),
        .gnt_idx_o   (gnt_idx_s)
    );

    // Load enable: register empty, or its word leaves this cycle (drain and refill together).
    assign en_s   = ~v_q | ready_and_i;
    assign yumi_o = (en_s && !reset_i) ? gnt_s : '0;

    // AND-OR data select over the one-hot grant.
    always_comb begin
        gnt_data_s = '0;
        for (int k = 0; k < els_p; k++) begin
            gnt_data_s = gnt_data_s | (data_i[k*width_p +: width_p] & {width_p{gnt_s[k]}});
        end
    end

    // Next state of the output register and round-robin pointer.
    always_comb begin
        v_d    = v_q;
        data_d = data_q;
        sel_d  = sel_q;
        last_d = last_q;
        if (en_s) begin
            v_d = |gnt_s;
            if (|gnt_s) begin
                data_d = gnt_data_s;
                sel_d  = gnt_idx_s;
                // Forced transfers do not disturb round-robin fairness.
                last_d = force_v_i ? last_q : gnt_idx_s;
            end else begin
                data_d = data_q;
                sel_d  = sel_q;
            end
        end else begin
            v_d = v_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            v_q    <= 1'b0;
            data_q <= '0;
            sel_q  <= '0;
            last_q <= last_init_lp;
        end else begin
            v_q    <= v_d;
            data_q <= data_d;
            sel_q  <= sel_d;
            last_q <= last_d;
        end
    end

    assign v_o    = v_q;
    assign data_o = data_q;
    assign sel_o  = sel_q;

    bsg_mux_rr_buffered_chk #(.width_p(width_p), .els_p(els_p)) u_chk (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .data_i  (data_i),
        .v_i     (v_i),
        .yumi_i  (yumi_o)
    );

endmodule

// File: tb/tb_bsg_mux_rr_buffered.sv
module tb_bsg_mux_rr_buffered;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;

    // Instance A: 4 channels x 64 bits
    logic         a_reset, a_fv, a_rdy, a_v_o;
    logic [255:0] a_data;
    logic [3:0]   a_v, a_yumi;
    logic [1:0]   a_fs, a_sel_o;
    logic [63:0]  a_data_o;

    // Instance B: 3 channels x 64 bits (force_sel can express an out-of-range index)
    logic         b_reset, b_fv, b_rdy, b_v_o;
    logic [191:0] b_data;
    logic [2:0]   b_v, b_yumi;
    logic [1:0]   b_fs, b_sel_o;
    logic [63:0]  b_data_o;

    bsg_mux_rr_buffered #(.width_p(64), .els_p(4)) dut_a (
        .clk_i(clk), .reset_i(a_reset), .data_i(a_data), .v_i(a_v), .yumi_o(a_yumi),
        .force_v_i(a_fv), .force_sel_i(a_fs), .data_o(a_data_o), .sel_o(a_sel_o),
        .v_o(a_v_o), .ready_and_i(a_rdy));

    bsg_mux_rr_buffered #(.width_p(64), .els_p(3)) dut_b (
        .clk_i(clk), .reset_i(b_reset), .data_i(b_data), .v_i(b_v), .yumi_o(b_yumi),
        .force_v_i(b_fv), .force_sel_i(b_fs), .data_o(b_data_o), .sel_o(b_sel_o),
        .v_o(b_v_o), .ready_and_i(b_rdy));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] pat(input int k);
        return 64'h1111_1111_1111_1111 * 64'(k);
    endfunction

    typedef struct {
        logic       rst;
        logic [3:0] v;
        logic       rdy;
        logic       fv;
        logic [1:0] fs;
        logic [3:0] exp_yumi;
        logic       exp_vo;
        logic [1:0] exp_sel;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rst, logic [3:0] v, logic rdy, logic fv, logic [1:0] fs,
                                logic [3:0] y, logic vo, logic [1:0] sel);
        vec_t r;
        r.rst = rst; r.v = v; r.rdy = rdy; r.fv = fv; r.fs = fs;
        r.exp_yumi = y; r.exp_vo = vo; r.exp_sel = sel;
        return r;
    endfunction

    task automatic b_row(input string name, input logic fv, input logic [1:0] fs,
                         input logic [2:0] v, input logic [2:0] ey, input logic evo,
                         input logic [63:0] edata);
        b_fv = fv; b_fs = fs; b_v = v;
        #1;
        chk({name, " yumi"}, 64'(b_yumi), 64'(ey));
        @(posedge clk); #1;
        chk({name, " v_o"}, 64'(b_v_o), 64'(evo));
        chk({name, " data_o"}, b_data_o, edata);
    endtask

    // Random-phase reference model state
    int      m_last;
    bit      m_v;
    logic [63:0] m_data;
    int      m_sel;
    bit      pv[4];
    longint  seq[4];
    longint  exp_seq[4];
    int      waitcnt[4];

    initial begin
        a_reset = 1'b1; a_fv = 1'b0; a_fs = 2'd0; a_rdy = 1'b1; a_v = 4'b1111;
        for (int k = 0; k < 4; k++) a_data[k*64 +: 64] = pat(k);
        b_reset = 1'b1; b_fv = 1'b0; b_fs = 2'd0; b_rdy = 1'b1; b_v = 3'b000;
        b_data = {64'h0F0F_0F0F_0F0F_0F0F, 64'hA5A5_A5A5_A5A5_A5A5, 64'h5A5A_5A5A_5A5A_5A5A};

        // ---- Reset held 3 cycles with all channels valid ----
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("reset yumi", 64'(a_yumi), 64'd0);
            @(posedge clk); #1;
            chk("reset v_o", 64'(a_v_o), 64'd0);
            chk("reset data_o", a_data_o, 64'd0);
            chk("reset sel_o", 64'(a_sel_o), 64'd0);
        end

        // ---- Table: rotation, reset, sparse wrap, stall/empty, force ----
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(1'b0, 4'b1111, 1'b1, 1'b0, 2'd0, 4'(1 << (i % 4)), 1'b1, 2'(i % 4)));
        tbl.push_back(mk(1'b1, 4'b1111, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 2'd0));
        tbl.push_back(mk(1'b0, 4'b0011, 1'b1, 1'b0, 2'd0, 4'b0001, 1'b1, 2'd0));
        tbl.push_back(mk(1'b0, 4'b0010, 1'b1, 1'b0, 2'd0, 4'b0010, 1'b1, 2'd1));
        tbl.push_back(mk(1'b0, 4'b1010, 1'b1, 1'b0, 2'd0, 4'b1000, 1'b1, 2'd3));
        tbl.push_back(mk(1'b0, 4'b1010, 1'b1, 1'b0, 2'd0, 4'b0010, 1'b1, 2'd1));
        tbl.push_back(mk(1'b0, 4'b1000, 1'b1, 1'b0, 2'd0, 4'b1000, 1'b1, 2'd3));
        tbl.push_back(mk(1'b0, 4'b0001, 1'b1, 1'b0, 2'd0, 4'b0001, 1'b1, 2'd0));
        tbl.push_back(mk(1'b0, 4'b0001, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, 2'd0));
        tbl.push_back(mk(1'b0, 4'b0001, 1'b1, 1'b0, 2'd0, 4'b0001, 1'b1, 2'd0));
        tbl.push_back(mk(1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 2'd0));
        tbl.push_back(mk(1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 2'd0));
        tbl.push_back(mk(1'b0, 4'b0100, 1'b0, 1'b0, 2'd0, 4'b0100, 1'b1, 2'd2));
        tbl.push_back(mk(1'b0, 4'b0100, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, 2'd2));
        tbl.push_back(mk(1'b0, 4'b0100, 1'b1, 1'b0, 2'd0, 4'b0100, 1'b1, 2'd2));
        tbl.push_back(mk(1'b0, 4'b0110, 1'b1, 1'b1, 2'd1, 4'b0010, 1'b1, 2'd1));
        tbl.push_back(mk(1'b0, 4'b0110, 1'b1, 1'b0, 2'd0, 4'b0010, 1'b1, 2'd1));
        tbl.push_back(mk(1'b0, 4'b0100, 1'b1, 1'b0, 2'd0, 4'b0100, 1'b1, 2'd2));

        for (int i = 0; i < tbl.size(); i++) begin
            a_reset = tbl[i].rst; a_v = tbl[i].v; a_rdy = tbl[i].rdy;
            a_fv = tbl[i].fv; a_fs = tbl[i].fs;
            #1;
            chk($sformatf("tbl%0d yumi", i), 64'(a_yumi), 64'(tbl[i].exp_yumi));
            @(posedge clk); #1;
            chk($sformatf("tbl%0d v_o", i), 64'(a_v_o), 64'(tbl[i].exp_vo));
            chk($sformatf("tbl%0d sel_o", i), 64'(a_sel_o), 64'(tbl[i].exp_sel));
            chk($sformatf("tbl%0d data_o", i), a_data_o, pat(int'(tbl[i].exp_sel)));
        end

        // ---- Stall 5 cycles, then drain+refill with no bubble, then mid-run reset ----
        a_reset = 1'b1; a_v = 4'b1111; a_rdy = 1'b1; a_fv = 1'b0;
        @(posedge clk); #1;
        a_reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("stall pre yumi", 64'(a_yumi), 64'(4'(1 << i)));
            @(posedge clk); #1;
            chk("stall pre sel_o", 64'(a_sel_o), 64'(i));
        end
        a_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall yumi", 64'(a_yumi), 64'd0);
            @(posedge clk); #1;
            chk("stall v_o", 64'(a_v_o), 64'd1);
            chk("stall data_o", a_data_o, pat(1));
            chk("stall sel_o", 64'(a_sel_o), 64'd1);
        end
        a_rdy = 1'b1;
        #1;
        chk("refill yumi", 64'(a_yumi), 64'b0100);
        @(posedge clk); #1;
        chk("refill v_o", 64'(a_v_o), 64'd1);
        chk("refill data_o", a_data_o, pat(2));
        a_reset = 1'b1;
        #1;
        chk("midreset yumi", 64'(a_yumi), 64'd0);
        @(posedge clk); #1;
        chk("midreset v_o", 64'(a_v_o), 64'd0);

        // ---- Forced select on the 3-channel instance ----
        @(posedge clk); #1;
        b_reset = 1'b0; b_v = 3'b011;
        b_row("force1",   1'b1, 2'd1, 3'b011, 3'b010, 1'b1, 64'hA5A5_A5A5_A5A5_A5A5);
        b_row("force_oor",1'b1, 2'd3, 3'b011, 3'b000, 1'b0, 64'hA5A5_A5A5_A5A5_A5A5);
        b_row("rr_after", 1'b0, 2'd0, 3'b011, 3'b001, 1'b1, 64'h5A5A_5A5A_5A5A_5A5A);
        b_row("force1b",  1'b1, 2'd1, 3'b011, 3'b010, 1'b1, 64'hA5A5_A5A5_A5A5_A5A5);
        b_row("ptr_kept", 1'b0, 2'd0, 3'b011, 3'b010, 1'b1, 64'hA5A5_A5A5_A5A5_A5A5);
        b_reset = 1'b1;

        // ---- Random traffic against a transaction-level reference ----
        a_reset = 1'b1;
        @(posedge clk); #1;
        a_reset = 1'b0;
        m_last = 3; m_v = 1'b0; m_data = 64'd0; m_sel = 0;
        for (int k = 0; k < 4; k++) begin
            pv[k] = 1'b0; seq[k] = 0; exp_seq[k] = 0; waitcnt[k] = 0;
        end
        for (int cyc = 0; cyc < 10000; cyc++) begin
            int g;
            bit en;
            logic [3:0] ey;
            a_rdy = ($urandom_range(0, 3) != 0);
            a_fv  = ($urandom_range(0, 15) == 0);
            a_fs  = 2'($urandom_range(0, 3));
            for (int k = 0; k < 4; k++) begin
                a_v[k] = pv[k];
                a_data[k*64 +: 64] = {8'(k), 56'(seq[k])};
            end
            #1;
            en = !m_v || a_rdy;
            g = -1;
            if (a_fv) begin
                if (pv[a_fs]) g = int'(a_fs);
            end else begin
                for (int j = 1; j <= 4; j++)
                    if (g < 0 && pv[(m_last + j) % 4]) g = (m_last + j) % 4;
            end
            ey = (en && g >= 0) ? 4'(1 << g) : 4'd0;
            chk("rand yumi", 64'(a_yumi), 64'(ey));
            // Consumed word: must be the next unseen word of its channel.
            if (m_v && a_rdy)
                chk("rand order", a_data_o, {8'(a_sel_o), 56'(exp_seq[a_sel_o])});
            if (m_v && a_rdy) exp_seq[m_sel]++;
            // Fairness over round-robin grants actually issued by the DUT.
            if (!a_fv && a_yumi != 4'd0) begin
                for (int k = 0; k < 4; k++) begin
                    if (a_yumi[k] || !pv[k]) waitcnt[k] = 0;
                    else begin
                        waitcnt[k]++;
                        chk($sformatf("fair ch%0d", k), 64'(waitcnt[k] <= 3), 64'd1);
                    end
                end
            end
            @(posedge clk); #1;
            if (en) begin
                m_v = (g >= 0);
                if (g >= 0) begin
                    m_data = {8'(g), 56'(seq[g])};
                    m_sel  = g;
                    if (!a_fv) m_last = g;
                end
            end
            chk("rand v_o", 64'(a_v_o), 64'(m_v));
            chk("rand sel_o", 64'(a_sel_o), 64'(m_sel));
            chk("rand data_o", a_data_o, m_data);
            for (int k = 0; k < 4; k++) begin
                if (pv[k] && ey[k]) begin
                    seq[k]++;
                    pv[k] = ($urandom_range(0, 3) != 0);
                end else if (!pv[k]) begin
                    pv[k] = ($urandom_range(0, 1) != 0);
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
